prbs_seq_ctrl: RTL and testbench
================================

Name: prbs_seq_ctrl

Overview:
- Sequencing controller for the project's PRBS generator. It owns a configurable LFSR core, accepts single-cycle commands (load seed, start burst, stop, inject error) over a valid/ready port, and produces a gated PRBS bit stream plus a parallel byte view for uo_out.
- Sits between the ui_in/uio_in command decode and the output pins. It is the block that decides when the LFSR steps, from what seed, for how many bits.

Parameters:
- LFSR_W, 31, physical LFSR register width; must be >= 31.
- CNT_W, 8, burst length/count width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at posedge clk
- cmd_op  in  2  00 LOAD_SEED, 01 START, 10 STOP, 11 INJECT
- cmd_arg  in  CNT_W  LOAD_SEED: seed low byte; START: burst length (0 = continuous)
- mode  in  2  00 PRBS7 (taps 7,6), 01 PRBS9 (9,5), 10 PRBS15 (15,14), 11 PRBS31 (31,28); sampled on START only
- step_en  in  1  clock enable for stepping while RUN
- prbs_bit  out  1  serial output bit, possibly error-inverted
- prbs_valid  out  1  prbs_bit is a fresh step this cycle
- prbs_byte  out  8  LFSR state[7:0]
- busy  out  1  state == RUN
- done  out  1  one-cycle pulse on burst completion or STOP

Behaviour:
- Reset values (async, immediate): FSM IDLE; LFSR state = 1; seed reg = 1; active mode = PRBS7; count = 0; inject_pending = 0. Outputs: prbs_bit = 0, prbs_valid = 0, prbs_byte = 0x01, busy = 0, done = 0, cmd_ready = 1.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on accepted START.
  - RUN -> DONE on final burst step or accepted STOP.
  - DONE -> IDLE unconditionally after 1 cycle.
- cmd_ready = 0 only in DONE; 1 in IDLE and RUN.
- LOAD_SEED (any state):
  - seed reg <= {0..., cmd_arg}; cmd_arg == 0 loads 1 (no lock-up seed).
  - Does not disturb a running LFSR; takes effect at the next START.
- START in IDLE:
  - LFSR <= seed, active mode <= mode, burst_len <= cmd_arg, count <= 0, FSM <= RUN.
  - The first step occurs on the first RUN cycle with step_en = 1.
- START in RUN: restart with the same actions (re-seed, count cleared); no done pulse.
- Step, in RUN with step_en = 1, where n/m are the taps of the active mode:
  - fb = s[n-1] ^ s[m-1]; s <= ({s[LFSR_W-2:0], fb}) masked to the low n bits.
  - That same cycle, prbs_valid = 1 and prbs_bit = s[n-1] ^ inject_pending (combinational from pre-step state); inject_pending then clears.
  - count += 1.
- step_en = 0 in RUN: LFSR and count hold, prbs_valid = 0.
- Burst end: burst_len != 0 and a step occurs with count == burst_len - 1 -> FSM <= DONE. Exactly burst_len valid cycles per burst. burst_len == 0 runs until STOP; count wraps silently.
- STOP:
  - In RUN: FSM <= DONE. A step in the same cycle still happens and is valid.
  - In IDLE: accepted, no effect, no done pulse.
- INJECT: inject_pending <= 1 in any state. Consumed by the next valid step; it persists across IDLE and START. Back-to-back INJECTs before a step collapse into one inversion. Injection never alters LFSR state.
- Simultaneous STOP and final burst step: a single DONE and a single done pulse.
- done = 1 exactly in the DONE cycle; busy = 0 there.
- LFSR state is preserved into IDLE, so prbs_byte shows the last state.
- rst_n low mid-RUN: all state returns to reset values asynchronously. No done pulse on reset release.

Decomposition:
- Package prbs_pkg:
  - op codes OP_LOAD_SEED/OP_START/OP_STOP/OP_INJECT;
  - mode codes;
  - per-mode tap constants (n, m);
  - FSM state enum.
- Sub-module prbs_lfsr: LFSR_W register with load, step enable, mode-selected taps and masking; outputs state and out bit.
- The controller keeps the FSM, counter, seed and inject logic.

Test Plan:
- Reset, then START arg = 0, mode PRBS7, default seed, step_en = 1: prbs_byte sequence 0x01, 0x02, 0x04, 0x08, 0x10, 0x20, 0x41, 0x03. State returns to 0x01 after exactly 127 steps, not earlier.
- LOAD_SEED 0x00, then START arg = 5, mode PRBS15: seed is 1; exactly 5 prbs_valid cycles; done pulses once on the cycle after the 5th step; cmd_ready = 0 that cycle; busy falls.
- START arg = 10 with step_en toggling 1,0,1,0...: still exactly 10 valid bits, spread over 19 cycles; LFSR holds on disabled cycles.
- Run PRBS31 continuously, INJECT at step 20: only bit 20 inverted versus the golden model; subsequent bits match; two INJECTs before one step invert only one bit.
- START arg = 3 with STOP accepted on the 3rd step cycle: one done pulse, 3 valid bits. STOP in IDLE: no done pulse, state unchanged.
- rst_n asserted mid-burst: outputs immediately at reset values (prbs_byte = 0x01, busy = 0); after release, no done pulse and cmd_ready = 1.

Source files
------------

// File: rtl/prbs_pkg.sv
// Shared op codes, mode codes, tap tables and FSM encoding for the PRBS sequencing controller.
package prbs_pkg;

  typedef enum logic [1:0] {
    OP_LOAD_SEED = 2'b00,
    OP_START     = 2'b01,
    OP_STOP      = 2'b10,
    OP_INJECT    = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    MODE_PRBS7  = 2'b00,
    MODE_PRBS9  = 2'b01,
    MODE_PRBS15 = 2'b10,
    MODE_PRBS31 = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Polynomial length n (also the output tap) and the second tap m per mode.
  function automatic int unsigned tap_n(input mode_e md);
    case (md)
      MODE_PRBS7:  tap_n = 7;
      MODE_PRBS9:  tap_n = 9;
      MODE_PRBS15: tap_n = 15;
      default:     tap_n = 31;
    endcase
  endfunction

  function automatic int unsigned tap_m(input mode_e md);
    case (md)
      MODE_PRBS7:  tap_m = 6;
      MODE_PRBS9:  tap_m = 5;
      MODE_PRBS15: tap_m = 14;
      default:     tap_m = 28;
    endcase
  endfunction

endpackage

// File: rtl/prbs_seq_ctrl_lfsr.sv
// Fibonacci LFSR with mode-selected taps; the active polynomial length masks the register.
module prbs_lfsr
  import prbs_pkg::*;
#(
  parameter int unsigned LFSR_W = 31
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              step,
  input  mode_e             mode,
  output logic [7:0]        state_lo,
  output logic              out_bit
);

  localparam int unsigned IW = $clog2(LFSR_W);
  localparam int unsigned LW = IW + 1;

  logic [LFSR_W-1:0] state;
  logic [LFSR_W-1:0] mask;
  logic [LFSR_W-1:0] state_next;
  logic [IW-1:0]     n_idx;
  logic [IW-1:0]     m_idx;
  logic [LW-1:0]     n_len;
  logic              fb;

  always_comb begin
    n_len      = LW'(tap_n(mode));
    n_idx      = IW'(tap_n(mode) - 1);
    m_idx      = IW'(tap_m(mode) - 1);
    out_bit    = state[n_idx];
    fb         = state[n_idx] ^ state[m_idx];
    mask       = ~({LFSR_W{1'b1}} << n_len);
    state_next = {state[LFSR_W-2:0], fb} & mask;
  end

  // Load wins over step so a restart always begins from the seed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LFSR_W'(1);
    end else if (load) begin
      state <= seed;
    end else if (step) begin
      state <= state_next;
    end
  end

  assign state_lo = state[7:0];

endmodule

// File: rtl/prbs_seq_ctrl.sv
// PRBS sequencing controller: command port, burst FSM, seed and error-injection handling.
module prbs_seq_ctrl
  import prbs_pkg::*;
#(
  parameter int unsigned LFSR_W = 31,
  parameter int unsigned CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_arg,
  input  logic [1:0]       mode,
  input  logic             step_en,
  output logic             prbs_bit,
  output logic             prbs_valid,
  output logic [7:0]       prbs_byte,
  output logic             busy,
  output logic             done
);

  state_e            state_q;
  state_e            state_d;
  mode_e             mode_q;
  logic [LFSR_W-1:0] seed_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  len_q;
  logic              inject_q;

  logic              accept;
  logic              start_acc;
  logic              stop_acc;
  logic              load_acc;
  logic              inj_acc;
  logic              step;
  logic              last_step;
  logic              lfsr_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    cmd_ready  = (state_q != ST_DONE);
    accept     = cmd_valid & cmd_ready;
    start_acc  = accept && (op_e'(cmd_op) == OP_START);
    stop_acc   = accept && (op_e'(cmd_op) == OP_STOP);
    load_acc   = accept && (op_e'(cmd_op) == OP_LOAD_SEED);
    inj_acc    = accept && (op_e'(cmd_op) == OP_INJECT);
    step       = (state_q == ST_RUN) && step_en;
    last_step  = step && (len_q != '0) && (count_q == len_q - CNT_W'(1));
    busy       = (state_q == ST_RUN);
    done       = (state_q == ST_DONE);
    prbs_valid = step;
    prbs_bit   = step & (lfsr_bit ^ inject_q);

    case (state_q)
      ST_IDLE: if (start_acc) state_d = ST_RUN;
      // A restart keeps running; STOP and the final step share one DONE.
      ST_RUN: begin
        if (start_acc)                  state_d = ST_RUN;
        else if (stop_acc || last_step) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seed_q   <= LFSR_W'(1);
      mode_q   <= MODE_PRBS7;
      len_q    <= '0;
      count_q  <= '0;
      inject_q <= 1'b0;
    end else begin
      if (load_acc) seed_q <= (cmd_arg == '0) ? LFSR_W'(1) : LFSR_W'(cmd_arg);
      if (start_acc) begin
        mode_q  <= mode_e'(mode);
        len_q   <= cmd_arg;
        count_q <= '0;
      end else if (step) begin
        count_q <= count_q + CNT_W'(1);
      end
      // A new INJECT outranks consumption so it is never lost to a same-cycle step.
      if (inj_acc)   inject_q <= 1'b1;
      else if (step) inject_q <= 1'b0;
    end
  end

  prbs_lfsr #(
    .LFSR_W (LFSR_W)
  ) u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (start_acc),
    .seed     (seed_q),
    .step     (step),
    .mode     (mode_q),
    .state_lo (prbs_byte),
    .out_bit  (lfsr_bit)
  );

endmodule

// File: tb/tb_prbs_seq_ctrl.sv
// Scoreboard bench for prbs_seq_ctrl: driver feeds a behavioural model, monitor checks outputs.
module tb_prbs_seq_ctrl;
  import prbs_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] cmd_arg = 8'h00;
  logic [1:0] mode = 2'b00;
  logic       step_en = 1'b0;
  logic       prbs_bit;
  logic       prbs_valid;
  logic [7:0] prbs_byte;
  logic       busy;
  logic       done;

  prbs_seq_ctrl #(.LFSR_W(31), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_arg    (cmd_arg),
    .mode       (mode),
    .step_en    (step_en),
    .prbs_bit   (prbs_bit),
    .prbs_valid (prbs_valid),
    .prbs_byte  (prbs_byte),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  int nvalid  = 0;
  int ndone   = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
    end
  endtask

  typedef struct { int cyc; bit busy; bit done; bit ready; } st_t;
  typedef struct { int cyc; bit b; int by; } bit_t;
  st_t  st_q[$];
  bit_t bit_q[$];

  // Reference model: polynomial arithmetic on a longint, burst tracked as bits remaining.
  int     tn[4] = '{7, 9, 15, 31};
  int     tm[4] = '{6, 5, 14, 28};
  longint ms;
  int     m_seed, m_mode, bits_left;
  bit     m_inj, m_running, m_donecyc;

  function automatic longint lfsr_next(input longint s, input int md);
    longint fb;
    fb = ((s >> (tn[md] - 1)) ^ (s >> (tm[md] - 1))) & 1;
    return ((s << 1) | fb) & ((64'h1 << tn[md]) - 1);
  endfunction

  task automatic model_reset();
    ms = 1; m_seed = 1; m_mode = 0; bits_left = 0;
    m_inj = 0; m_running = 0; m_donecyc = 0;
  endtask

  task automatic model_eval(input bit v, input int op, input int arg, input int md, input bit se);
    bit acc, stp, fin, was_done;
    st_t  s;
    bit_t b;
    acc = v && !m_donecyc;
    stp = m_running && se;
    s.cyc = cyc; s.busy = m_running; s.done = m_donecyc; s.ready = !m_donecyc;
    st_q.push_back(s);
    if (stp) begin
      b.cyc = cyc;
      b.b   = bit'((ms >> (tn[m_mode] - 1)) & 1) ^ m_inj;
      b.by  = int'(ms & 8'hff);
      bit_q.push_back(b);
    end
    was_done  = m_donecyc;
    m_donecyc = 0;
    fin = 0;
    if (stp) m_inj = 0;
    if (acc && op == int'(OP_INJECT)) m_inj = 1;
    if (acc && op == int'(OP_LOAD_SEED)) m_seed = (arg == 0) ? 1 : arg;
    if (was_done) begin
      m_running = 0;
    end else if (acc && op == int'(OP_START)) begin
      ms = m_seed; m_mode = md; bits_left = arg; m_running = 1;
    end else if (m_running) begin
      if (stp) begin
        ms = lfsr_next(ms, m_mode);
        if (bits_left != 0) begin
          bits_left--;
          if (bits_left == 0) fin = 1;
        end
      end
      if (acc && op == int'(OP_STOP)) fin = 1;
      if (fin) begin
        m_running = 0;
        m_donecyc = 1;
      end
    end
  endtask

  task automatic tick(input bit v, input int op, input int arg, input int md, input bit se);
    @(posedge clk);
    #1;
    cmd_valid = v; cmd_op = 2'(op); cmd_arg = 8'(arg); mode = 2'(md); step_en = se;
    model_eval(v, op, arg, md, se);
  endtask

  task automatic idle(input int n, input bit se);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0, se);
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_byte"},  prbs_byte, 8'h01);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_done"},  done, 0);
    chk({tag, "_ready"}, cmd_ready, 1);
    chk({tag, "_valid"}, prbs_valid, 0);
    chk({tag, "_bit"},   prbs_bit, 0);
  endtask

  // Monitor: status every cycle, bit/byte whenever the DUT presents a valid step.
  always @(negedge clk) begin
    st_t  s;
    bit_t b;
    if (rst_n) begin
      if (prbs_valid) nvalid++;
      if (done) ndone++;
      if (st_q.size() == 0) begin
        chk("status_q_size", st_q.size(), 1);
      end else begin
        s = st_q.pop_front();
        chk("status_cyc", cyc, s.cyc);
        chk("busy", busy, s.busy);
        chk("done", done, s.done);
        chk("cmd_ready", cmd_ready, s.ready);
      end
      if (prbs_valid) begin
        if (bit_q.size() == 0) begin
          chk("unexpected_valid_q_size", bit_q.size(), 1);
        end else begin
          b = bit_q.pop_front();
          chk("valid_cyc", cyc, b.cyc);
          chk("prbs_bit", prbs_bit, b.b);
          chk("prbs_byte", prbs_byte, b.by);
        end
      end else if (bit_q.size() != 0 && bit_q[0].cyc == cyc) begin
        b = bit_q.pop_front();
        chk("prbs_valid", prbs_valid, 1);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int tbl[8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h41, 8'h03};
    int ret, v0, d0, r;
    logic [7:0] byte_hold;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk_reset_outputs("reset");
    #1 rst_n = 1'b1;

    // PRBS7 continuous from the default seed: sequence head and period.
    tick(1, OP_START, 0, MODE_PRBS7, 0);
    ret = -1;
    for (int i = 0; i < 130; i++) begin
      tick(0, 0, 0, 0, 1);
      if (i < 8) chk("prbs7_seq", prbs_byte, tbl[i]);
      if (i > 0 && ret < 0 && prbs_byte == 8'h01) ret = i;
    end
    chk("prbs7_period", ret, 127);
    tick(1, OP_STOP, 0, 0, 0);
    idle(2, 0);

    // Zero seed loads 1; burst of 5 in PRBS15.
    tick(1, OP_LOAD_SEED, 0, 0, 0);
    settle(); v0 = nvalid; d0 = ndone;
    tick(1, OP_START, 5, MODE_PRBS15, 1);
    tick(0, 0, 0, 0, 1);
    chk("seed_zero_is_one", prbs_byte, 8'h01);
    idle(9, 1);
    settle();
    chk("burst5_valid", nvalid - v0, 5);
    chk("burst5_done", ndone - d0, 1);

    // Burst of 10 with step_en toggling.
    v0 = nvalid; d0 = ndone;
    tick(1, OP_START, 10, MODE_PRBS9, 0);
    for (int i = 0; i < 26; i++) tick(0, 0, 0, 0, (i % 2) == 0);
    settle();
    chk("burst10_valid", nvalid - v0, 10);
    chk("burst10_done", ndone - d0, 1);

    // PRBS31 continuous with single and doubled injections.
    tick(1, OP_LOAD_SEED, 8'h5a, 0, 0);
    tick(1, OP_START, 0, MODE_PRBS31, 1);
    idle(20, 1);
    tick(1, OP_INJECT, 0, 0, 1);
    idle(6, 1);
    tick(1, OP_INJECT, 0, 0, 0);
    tick(1, OP_INJECT, 0, 0, 0);
    idle(6, 1);
    tick(1, OP_STOP, 0, 0, 0);
    idle(2, 0);

    // STOP on the final step of a 3-bit burst, then STOP in IDLE.
    settle(); v0 = nvalid; d0 = ndone;
    tick(1, OP_START, 3, MODE_PRBS9, 0);
    tick(0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 1);
    tick(1, OP_STOP, 0, 0, 1);
    idle(3, 0);
    settle();
    chk("stop_last_valid", nvalid - v0, 3);
    chk("stop_last_done", ndone - d0, 1);
    byte_hold = prbs_byte; d0 = ndone;
    tick(1, OP_STOP, 0, 0, 1);
    idle(2, 1);
    settle();
    chk("stop_idle_done", ndone - d0, 0);
    chk("stop_idle_byte", prbs_byte, byte_hold);

    // Reset in the middle of a burst.
    tick(1, OP_LOAD_SEED, 8'h37, 0, 0);
    tick(1, OP_START, 50, MODE_PRBS15, 1);
    idle(7, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    cmd_valid = 0; step_en = 0;
    #1;
    chk_reset_outputs("midreset");
    model_reset();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    d0 = ndone;
    idle(3, 1);
    settle();
    chk("post_reset_done", ndone - d0, 0);
    chk("post_reset_ready", cmd_ready, 1);

    // Randomized command mix.
    for (int i = 0; i < 500; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 10)      tick(1, OP_LOAD_SEED, int'($urandom_range(0, 255)), 0, $urandom_range(0, 3) != 0);
      else if (r < 18) tick(1, OP_START, int'($urandom_range(0, 12)), int'($urandom_range(0, 3)), $urandom_range(0, 3) != 0);
      else if (r < 23) tick(1, OP_STOP, 0, 0, $urandom_range(0, 3) != 0);
      else if (r < 30) tick(1, OP_INJECT, 0, 0, $urandom_range(0, 3) != 0);
      else             tick(0, 0, 0, 0, $urandom_range(0, 3) != 0);
    end
    tick(1, OP_STOP, 0, 0, 0);
    idle(3, 0);
    settle();
    chk("bit_q_drained", bit_q.size(), 0);
    chk("st_q_drained", st_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
